// File: rtl/shift_operand_unit.sv
// -----------------------------------------------------------------------------
// shift_operand_unit
//
// Produces the second ALU operand (Val2) and the shifter carry-out for the
// execute stage. The supported modes are the rotated 8-bit immediate, a
// register shifted by a 5-bit immediate, a register shifted by a register
// amount, and the sign-extended 12-bit load/store offset.
//
// The default build shifts iteratively, up to STEP bits per cycle, so the
// latency is ceil(eff/STEP) cycles. Defining SHIFT_OPERAND_BARREL_EN selects a
// single-cycle barrel shifter instead. Both builds give identical result and
// carry_out values.
//
// Parameters
//   WIDTH  datapath width (power of two, >= 32)
//   STEP   max bits shifted per cycle in the iterative build (power of two)
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/ready request handshake (in_ready == state IDLE)
//   rm_val         operand register value
//   rs_val         shift-amount register, low byte
//   imm, ld_str    immediate mode / load-store offset mode (ld_str wins)
//   shift_operand  instruction operand field [11:0]
//   carry_in       current C flag
//   out_valid/ready result handshake (out_valid == state DONE)
//   result         registered Val2
//   carry_out      registered shifter carry
// -----------------------------------------------------------------------------
module shift_operand_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rm_val,
    input  logic [7:0]       rs_val,
    input  logic             imm,
    input  logic             ld_str,
    input  logic [11:0]      shift_operand,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

    // Shift v by n (1..WIDTH) and return {last bit out, shifted value}.
    // The extra guard bit on the LSL/LSR/ASR paths catches the bit leaving
    // the word, so an amount of exactly WIDTH needs no special case.
    function automatic logic [WIDTH:0] shift_fn(input op_t op,
                                                input logic [WIDTH-1:0] v,
                                                input logic [CW-1:0] n,
                                                input logic fill);
        logic [WIDTH:0]   t;
        logic [WIDTH:0]   u;
        logic [WIDTH-1:0] r;
        t = '0;
        u = '0;
        r = '0;
        case (op)
            OP_LSL: t = {1'b0, v} << n;
            OP_LSR: begin
                u = {v, 1'b0} >> n;
                t = {u[0], u[WIDTH:1]};
            end
            OP_ASR: begin
                u = $signed({v, 1'b0}) >>> n;
                t = {u[0], u[WIDTH:1]};
            end
            OP_ROR: begin
                r = (v >> n) | (v << (CW'(WIDTH) - n));
                t = {r[WIDTH-1], r};
            end
            OP_RRX:  t = {v[0], fill, v[WIDTH-1:1]};
            default: t = {fill, v};
        endcase
        return t;
    endfunction

    state_t          state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;   // doubles as the working shift register
    logic            carry_q, carry_d;      // carry_in on load, then last bit out
    logic [CW-1:0]   rem_q, rem_d;
    op_t             op_q, op_d;
    logic            kill_q, kill_d;        // LSL/LSR beyond WIDTH: carry forced to 0

    // ---------------- request decode ----------------
    op_t              dec_op;
    logic [WIDTH-1:0] dec_base;
    logic [CW-1:0]    dec_eff;
    logic             dec_c;
    logic             dec_kill;
    logic [31:0]      amt;

    always_comb begin
        dec_op   = OP_LSL;
        dec_base = rm_val;
        dec_eff  = '0;
        dec_c    = carry_in;
        dec_kill = 1'b0;
        amt      = shift_operand[4] ? {24'b0, rs_val} : {27'b0, shift_operand[11:7]};
        if (ld_str) begin
            dec_base = {{(WIDTH-12){shift_operand[11]}}, shift_operand};
        end else if (imm) begin
            dec_op   = OP_ROR;
            dec_base = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
            dec_eff  = CW'({shift_operand[11:8], 1'b0});
        end else begin
            case (shift_operand[6:5])
                2'b00: begin
                    dec_op = OP_LSL;
                    if (amt > 32'(WIDTH)) begin
                        dec_eff  = CW'(WIDTH);
                        dec_kill = 1'b1;
                    end else begin
                        dec_eff = amt[CW-1:0];
                    end
                end
                2'b01, 2'b10: begin
                    dec_op = (shift_operand[5]) ? OP_LSR : OP_ASR;
                    // Immediate amount of zero encodes a shift by 32.
                    if (!shift_operand[4] && amt == 32'd0) amt = 32'd32;
                    if (amt > 32'(WIDTH)) begin
                        dec_eff  = CW'(WIDTH);
                        dec_kill = shift_operand[5];  // ASR keeps sign-bit carry
                    end else begin
                        dec_eff = amt[CW-1:0];
                    end
                end
                default: begin
                    dec_op = OP_ROR;
                    if (!shift_operand[4] && amt == 32'd0) begin
                        dec_op  = OP_RRX;
                        dec_eff = CW'(1);
                    end else begin
                        dec_eff = CW'(amt & 32'(WIDTH - 1));
                        // Whole-word rotation: value unchanged, carry = MSB.
                        if (amt != 32'd0 && dec_eff == '0) dec_c = rm_val[WIDTH-1];
                    end
                end
            endcase
        end
    end

    // ---------------- iterative step ----------------
    logic [CW-1:0] step_n;
    logic [WIDTH:0] step_out;

    assign step_n   = (rem_q > CW'(STEP)) ? CW'(STEP) : rem_q;
    assign step_out = shift_fn(op_q, result_q, step_n, carry_q);

`ifdef SHIFT_OPERAND_BARREL_EN
    logic [WIDTH:0] bar_out;
    assign bar_out = shift_fn(dec_op, dec_base, dec_eff, dec_c);
`endif

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        rem_d    = rem_q;
        op_d     = op_q;
        kill_d   = kill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_OPERAND_BARREL_EN
                    state_d  = S_DONE;
                    result_d = (dec_eff == '0) ? dec_base : bar_out[WIDTH-1:0];
                    carry_d  = (dec_eff == '0) ? dec_c : (bar_out[WIDTH] & ~dec_kill);
`else
                    result_d = dec_base;
                    carry_d  = dec_c;
                    rem_d    = dec_eff;
                    op_d     = dec_op;
                    kill_d   = dec_kill;
                    state_d  = (dec_eff == '0) ? S_DONE : S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                result_d = step_out[WIDTH-1:0];
                rem_d    = rem_q - step_n;
                if (rem_q == step_n) begin
                    state_d = S_DONE;
                    carry_d = step_out[WIDTH] & ~kill_q;
                end else begin
                    carry_d = step_out[WIDTH];
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            rem_q    <= '0;
            op_q     <= OP_LSL;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            kill_q   <= kill_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_operand_unit.sv
module tb_shift_operand_unit;
    localparam int W  = 32;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  rm_val = '0;
    logic [7:0]    rs_val = '0;
    logic          imm = 1'b0;
    logic          ld_str = 1'b0;
    logic [11:0]   shift_operand = '0;
    logic          carry_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          carry_out;

    int n_cmp = 0;
    int n_err = 0;

    shift_operand_unit #(.WIDTH(W), .STEP(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rm_val(rm_val), .rs_val(rs_val), .imm(imm), .ld_str(ld_str),
        .shift_operand(shift_operand), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    // Reference model: applies the operand rules directly on 32-bit values.
    function automatic void model(input bit ld, input bit im, input logic [11:0] so,
                                  input logic [31:0] rm, input logic [7:0] rs, input bit cin,
                                  output logic [31:0] r, output logic c, output int eff);
        int amt;
        int e;
        logic [31:0] base;
        if (ld) begin
            r = {{20{so[11]}}, so}; c = cin; eff = 0;
        end else if (im) begin
            amt  = 2 * int'(so[11:8]);
            base = {24'b0, so[7:0]};
            if (amt == 0) begin r = base; c = cin; end
            else begin r = (base >> amt) | (base << (32 - amt)); c = r[31]; end
            eff = amt;
        end else begin
            amt = so[4] ? int'(rs) : int'(so[11:7]);
            if (!so[4] && amt == 0 && so[6:5] == 2'b11) begin
                r = {cin, rm[31:1]}; c = rm[0]; eff = 1;
            end else begin
                if (!so[4] && amt == 0 && (so[6:5] == 2'b01 || so[6:5] == 2'b10)) amt = 32;
                eff = (amt > 32) ? 32 : amt;
                if (amt == 0) begin
                    r = rm; c = cin; eff = 0;
                end else begin
                    case (so[6:5])
                        2'b00: if (amt < 32) begin r = rm << amt; c = rm[32-amt]; end
                               else if (amt == 32) begin r = 0; c = rm[0]; end
                               else begin r = 0; c = 0; end
                        2'b01: if (amt < 32) begin r = rm >> amt; c = rm[amt-1]; end
                               else if (amt == 32) begin r = 0; c = rm[31]; end
                               else begin r = 0; c = 0; end
                        2'b10: if (amt >= 32) begin r = {32{rm[31]}}; c = rm[31]; end
                               else begin r = $signed(rm) >>> amt; c = rm[amt-1]; end
                        default: begin
                            e = amt % 32;
                            eff = e;
                            if (e == 0) begin r = rm; c = rm[31]; end
                            else begin r = (rm >> e) | (rm << (32 - e)); c = r[31]; end
                        end
                    endcase
                end
            end
        end
    endfunction

    // Drive one request; returns one time unit after the accepting edge,
    // with the request inputs scrambled so late changes would show.
    task automatic send_req(input bit ld, input bit im, input logic [11:0] so,
                            input logic [31:0] rm, input logic [7:0] rs, input bit cin);
        @(negedge clk);
        ld_str = ld; imm = im; shift_operand = so; rm_val = rm; rs_val = rs;
        carry_in = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ld_str = 1'($urandom); imm = 1'($urandom); shift_operand = 12'($urandom);
        rm_val = $urandom; rs_val = 8'($urandom); carry_in = 1'($urandom);
    endtask

    // Counts edges after accept until out_valid; bounded at 64.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({in_ready, out_valid, result, carry_out} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b res=%h c=%b, want 1 0 00000000 0",
                     in_ready, out_valid, result, carry_out);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_lsl_imm();
        int cyc;
        send_req(0, 0, 12'h200, 32'h8000000F, 8'd0, 0);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'h000000F0, 1'b0} || cyc !== 1) begin
            n_err++;
            $display("FAIL lsl4: res=%h c=%b cyc=%0d, want 000000F0 0 1", result, carry_out, cyc);
        end
        release_out();
    endtask

    task automatic test_rotate_imm();
        int cyc;
        send_req(0, 1, 12'h4FF, 32'h12345678, 8'd0, 0);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'hFF000000, 1'b1} || cyc !== 2) begin
            n_err++;
            $display("FAIL rot_imm: res=%h c=%b cyc=%0d, want FF000000 1 2", result, carry_out, cyc);
        end
        release_out();
    endtask

    task automatic test_saturate();
        int cyc;
        send_req(0, 0, 12'h050, 32'h80000000, 8'd40, 0);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'hFFFFFFFF, 1'b1} || cyc !== 8) begin
            n_err++;
            $display("FAIL asr40: res=%h c=%b cyc=%0d, want FFFFFFFF 1 8", result, carry_out, cyc);
        end
        release_out();
        send_req(0, 0, 12'h030, 32'hFFFFFFFF, 8'd33, 1);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'h0, 1'b0} || cyc !== 8) begin
            n_err++;
            $display("FAIL lsr33: res=%h c=%b cyc=%0d, want 00000000 0 8", result, carry_out, cyc);
        end
        release_out();
    endtask

    task automatic test_lsr32_rrx();
        int cyc;
        send_req(0, 0, 12'h020, 32'h80000000, 8'd0, 0);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'h0, 1'b1} || cyc !== 8) begin
            n_err++;
            $display("FAIL lsr32: res=%h c=%b cyc=%0d, want 00000000 1 8", result, carry_out, cyc);
        end
        release_out();
        send_req(0, 0, 12'h060, 32'h00000003, 8'd0, 1);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'h80000001, 1'b1} || cyc !== 1) begin
            n_err++;
            $display("FAIL rrx: res=%h c=%b cyc=%0d, want 80000001 1 1", result, carry_out, cyc);
        end
        release_out();
    endtask

    task automatic test_ldstr_hold();
        int cyc;
        send_req(1, 1, 12'hFFC, 32'h0, 8'd0, 1);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {32'hFFFFFFFC, 1'b1} || cyc !== 0) begin
            n_err++;
            $display("FAIL ldstr: res=%h c=%b cyc=%0d, want FFFFFFFC 1 0", result, carry_out, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ld_str = 1'b0; imm = 1'b1; shift_operand = 12'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if ({result, carry_out, out_valid, in_ready} !== {32'hFFFFFFFC, 1'b1, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL hold%0d: res=%h c=%b vld=%b rdy=%b, want FFFFFFFC 1 1 0",
                         i, result, carry_out, out_valid, in_ready);
            end
        end
        @(negedge clk); in_valid = 1'b0;
        release_out();
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL after_hold: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] er;
        logic ec;
        int ee;
        send_req(0, 0, 12'h030, 32'hFFFFFFFF, 8'd32, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result, carry_out} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid: vld=%b rdy=%b res=%h c=%b, want 0 1 00000000 0",
                     out_valid, in_ready, result, carry_out);
        end
        @(negedge clk); rst = 1'b0;
        model(0, 0, 12'h0A0, 32'hC0000005, 8'd0, 0, er, ec, ee);
        send_req(0, 0, 12'h0A0, 32'hC0000005, 8'd0, 0);
        wait_done(cyc);
        n_cmp++;
        if ({result, carry_out} !== {er, ec} || cyc !== (ee + ST - 1) / ST) begin
            n_err++;
            $display("FAIL post_rst: res=%h c=%b cyc=%0d, want %h %b %0d",
                     result, carry_out, cyc, er, ec, (ee + ST - 1) / ST);
        end
        release_out();
    endtask

    task automatic test_random();
        int cyc;
        int ee;
        logic [31:0] er, rm;
        logic ec;
        logic [11:0] so;
        logic [7:0] rs;
        bit ld, im, cin;
        logic [7:0] edges [5];
        edges = '{8'd0, 8'd31, 8'd32, 8'd33, 8'd64};
        for (int i = 0; i < 150; i++) begin
            ld  = ($urandom_range(0, 7) == 0);
            im  = ($urandom_range(0, 3) == 0);
            so  = 12'($urandom);
            rm  = $urandom;
            rs  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : 8'($urandom);
            cin = 1'($urandom);
            model(ld, im, so, rm, rs, cin, er, ec, ee);
            send_req(ld, im, so, rm, rs, cin);
            wait_done(cyc);
            n_cmp++;
            if ({result, carry_out} !== {er, ec} || cyc !== (ee + ST - 1) / ST) begin
                n_err++;
                $display("FAIL rand%0d: ld=%b im=%b so=%h rm=%h rs=%0d ci=%b got %h %b cyc=%0d want %h %b cyc=%0d",
                         i, ld, im, so, rm, rs, cin, result, carry_out, cyc, er, ec, (ee + ST - 1) / ST);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            release_out();
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rand_rdy%0d: rdy=%b, want 1", i, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsl_imm();
        test_rotate_imm();
        test_saturate();
        test_lsr32_rrx();
        test_ldstr_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
